wb_cmd_master: RTL and testbench
================================

# wb_cmd_master

Single-outstanding Wishbone classic-cycle initiator that turns a valid/ready command stream into one bus read or write and returns the result on a valid/ready response stream. It is the upstream partner of the Wishbone slaves on the flight-controller bus (version register, PWM, DSHOT), and it sits between the SPI command decoder and the Wishbone interconnect.

## Interface
- DATA_WIDTH, 32: Wishbone data width; must be a multiple of 8.
- ADDR_WIDTH, 32: Wishbone address width.
- TIMEOUT_CYCLES, 255: maximum number of cycles spent waiting for ack/err, used only when the timeout feature is compiled in; must be ≥ 1.

- i_clk  in  1  single clock for all logic.
- i_rst  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when both valid and ready are high at a rising edge.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADDR_WIDTH  target address.
- cmd_dat_i  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed when both valid and ready are high at a rising edge.
- rsp_dat_o  out  DATA_WIDTH  read data; 0 for writes and for errors.
- rsp_err_o  out  1  bus error or timeout.
- wb_adr_o  out  ADDR_WIDTH  bus address.
- wb_dat_o  out  DATA_WIDTH  bus write data.
- wb_dat_i  in  DATA_WIDTH  bus read data.
- wb_we_o  out  1  bus write enable.
- wb_sel_o  out  DATA_WIDTH/8  byte selects; all ones during a cycle.
- wb_stb_o, wb_cyc_o  out  1  strobe and cycle.
- wb_ack_i, wb_err_i  in  1  slave termination.
- busy_o  out  1  high in any state other than IDLE.

## Operation
- State machine with three states: IDLE, BUS, RESP.
- IDLE
  - cmd_ready_o = 1.
  - On accept: latch we, adr and dat into the wb_* output registers, set cyc = stb = 1, sel = all ones, clear the timeout counter, then go to BUS.
- BUS
  - cyc, stb, adr, we and dat are held stable.
  - cmd_ready_o = 0.
  - wb_ack_i: drop cyc/stb at the same edge. rsp_dat_o = wb_dat_i for a read and 0 for a write. rsp_err_o = 0. Go to RESP.
  - wb_err_i: drop cyc/stb. rsp_dat_o = 0, rsp_err_o = 1. Go to RESP.
  - ack and err high in the same cycle: err wins.
- RESP
  - rsp_valid_o = 1, and rsp_dat_o/rsp_err_o are held until the handshake.
  - cmd_ready_o = 0, which gives no command/response overlap.
  - On rsp_ready_i: go to IDLE, clear rsp_valid_o.
- ack/err in IDLE or RESP: ignored, with no state change.
- Reset: takes effect at the next edge from any state, including mid-cycle. All outputs are registered and reset as follows:
  - cyc, stb, we = 0; sel, adr, dat = 0
  - rsp_valid_o = 0, rsp_err_o = 0, rsp_dat_o = 0
  - cmd_ready_o = 0 during reset and 1 from the first cycle after reset releases
  - busy_o = 0
  - state = IDLE
  - A transaction in flight is dropped with no response.

## Timing
- Command accepted at edge N → cyc/stb high from N+1.
- Registered-ack slave (acks one cycle after seeing stb) → ack sampled at edge N+2, cyc/stb low after N+2, rsp_valid_o high after N+2.
- Accept-to-response latency is 2 cycles plus slave wait states.
- rsp_ready_i held high → IDLE after N+3, next command accepted at N+4 at the earliest.
- A pulsed-ack slave sees exactly one cycle of ack, because stb falls the cycle after ack.
- Throughput is at most one transaction per 4 cycles with a zero-wait-state registered slave.

## Configuration
- WB_MASTER_TIMEOUT_EN defined
  - Counter of width $clog2(TIMEOUT_CYCLES+1) increments every BUS cycle.
  - Counter reaches TIMEOUT_CYCLES with no ack/err: drop cyc/stb, rsp_err_o = 1, rsp_dat_o = 0, go to RESP.
  - ack or err in the same cycle the timeout fires: the termination wins, with normal ack/err handling.
  - The counter saturates and never wraps.
- WB_MASTER_TIMEOUT_EN undefined
  - No counter is built; BUS waits indefinitely.
  - TIMEOUT_CYCLES is unused.

## Test plan
- Read, registered-ack slave returning 32'hDEADBEEF at adr 32'h0000_0010
  - Command accepted at N → cyc/stb high for exactly 2 cycles, single ack.
  - Response: rsp_dat_o = 32'hDEADBEEF, rsp_err_o = 0, rsp_valid_o high after N+2.
- Write of 32'h1234_5678 to 32'h0000_0004
  - wb_we_o = 1, wb_dat_o = 32'h1234_5678, wb_sel_o = 4'hF for the whole cycle.
  - Response: rsp_dat_o = 0, rsp_err_o = 0.
- Response back-pressure: rsp_ready_i low for 5 cycles
  - rsp_valid_o and rsp_dat_o stay stable and cmd_ready_o stays 0 throughout.
  - Handshake on cycle 6, then cmd_ready_o = 1 on the next cycle.
- Slave asserts ack and err together in the same cycle after 3 wait states
  - rsp_err_o = 1, rsp_dat_o = 0.
- Timeout (macro defined, TIMEOUT_CYCLES = 8), slave never responds
  - cyc/stb drop after 8 BUS cycles, rsp_err_o = 1.
  - Repeat with ack arriving in exactly the timeout cycle → rsp_err_o = 0 with the ack data.
- Reset mid-cycle: i_rst pulsed while in BUS
  - cyc/stb/rsp_valid_o = 0 after that edge, no response emitted.
  - After release, the next command completes normally.

Source files
------------

// File: rtl/wb_cmd_master_if.sv
// rtl/wb_cmd_master_if.sv - command/response and Wishbone signal bundle for wb_cmd_master
interface wb_cmd_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic                    cmd_we_i;
  logic [ADDR_WIDTH-1:0]   cmd_adr_i;
  logic [DATA_WIDTH-1:0]   cmd_dat_i;
  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [DATA_WIDTH-1:0]   rsp_dat_o;
  logic                    rsp_err_o;
  logic [ADDR_WIDTH-1:0]   wb_adr_o;
  logic [DATA_WIDTH-1:0]   wb_dat_o;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic                    wb_we_o;
  logic [DATA_WIDTH/8-1:0] wb_sel_o;
  logic                    wb_stb_o;
  logic                    wb_cyc_o;
  logic                    wb_ack_i;
  logic                    wb_err_i;
  logic                    busy_o;

  // Bus initiator view
  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i,
           wb_dat_i, wb_ack_i, wb_err_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
           wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o, busy_o
  );

  // Environment view: command source, response sink and Wishbone slave
  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i,
           wb_dat_i, wb_ack_i, wb_err_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
           wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o, busy_o
  );
endinterface

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - single-outstanding Wishbone classic initiator (optional timeout: WB_MASTER_TIMEOUT_EN)
module wb_cmd_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           i_clk,
  input  logic           i_rst,
  wb_cmd_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t state;
  logic   tmo_fire;

  // Parameter sanity hook: illegal combinations elaborate an empty marker block
  if (TIMEOUT_CYCLES < 1 || (DATA_WIDTH % 8) != 0) begin : g_bad_params
  end

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt;

  // Fires on the BUS edge that completes the TIMEOUT_CYCLES-th waiting cycle
  assign tmo_fire = (tmo_cnt >= TMO_LAST);
`else
  assign tmo_fire = 1'b0;
`endif

  // Control FSM with all outputs registered
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= IDLE;
      bus.cmd_ready_o <= 1'b0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_dat_o   <= '0;
      bus.rsp_err_o   <= 1'b0;
      bus.wb_adr_o    <= '0;
      bus.wb_dat_o    <= '0;
      bus.wb_we_o     <= 1'b0;
      bus.wb_sel_o    <= '0;
      bus.wb_stb_o    <= 1'b0;
      bus.wb_cyc_o    <= 1'b0;
      bus.busy_o      <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.cmd_ready_o <= 1'b1;
          if (bus.cmd_ready_o && bus.cmd_valid_i) begin
            bus.wb_adr_o    <= bus.cmd_adr_i;
            bus.wb_dat_o    <= bus.cmd_dat_i;
            bus.wb_we_o     <= bus.cmd_we_i;
            bus.wb_sel_o    <= '1;
            bus.wb_cyc_o    <= 1'b1;
            bus.wb_stb_o    <= 1'b1;
            bus.cmd_ready_o <= 1'b0;
            bus.busy_o      <= 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt         <= '0;
`endif
            state           <= BUS;
          end
        end

        BUS: begin
`ifdef WB_MASTER_TIMEOUT_EN
          if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
`endif
          // err outranks ack; any slave termination outranks the timeout
          if (bus.wb_err_i || (!bus.wb_ack_i && tmo_fire)) begin
            bus.wb_cyc_o    <= 1'b0;
            bus.wb_stb_o    <= 1'b0;
            bus.rsp_dat_o   <= '0;
            bus.rsp_err_o   <= 1'b1;
            bus.rsp_valid_o <= 1'b1;
            state           <= RESP;
          end else if (bus.wb_ack_i) begin
            bus.wb_cyc_o    <= 1'b0;
            bus.wb_stb_o    <= 1'b0;
            bus.rsp_dat_o   <= bus.wb_we_o ? '0 : bus.wb_dat_i;
            bus.rsp_err_o   <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            state           <= RESP;
          end
        end

        RESP: begin
          if (bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
            bus.cmd_ready_o <= 1'b1;
            bus.busy_o      <= 1'b0;
            state           <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - self-checking bench for wb_cmd_master (honours WB_MASTER_TIMEOUT_EN)
module tb_wb_cmd_master;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TMO = 8;
`ifdef WB_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int T_ACK  = 0;
  localparam int T_ERR  = 1;
  localparam int T_BOTH = 2;
  localparam int T_NONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_cmd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  wb_cmd_master #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet_idle(input string tag);
    check({tag, "_ready"}, bus.cmd_ready_o, 1'b1);
    check({tag, "_cyc"},   bus.wb_cyc_o,    1'b0);
    check({tag, "_stb"},   bus.wb_stb_o,    1'b0);
    check({tag, "_valid"}, bus.rsp_valid_o, 1'b0);
    check({tag, "_busy"},  bus.busy_o,      1'b0);
  endtask

  // Idle cycles with stray slave terminations that must be ignored
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.wb_ack_i = 1'($urandom);
      bus.wb_err_i = 1'($urandom);
      bus.wb_dat_i = $urandom;
      @(negedge clk);
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
      check_quiet_idle("idle");
    end
  endtask

  // One full transaction; the slave terminates in BUS cycle 'lat' (1-based)
  task automatic txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                     input logic [DW-1:0] rdata, input int lat, input int term, input int bp);
    bit            timed;
    int            exp_len;
    logic          exp_err;
    logic [DW-1:0] exp_dat;
    logic [DW-1:0] held_dat;
    logic          held_err;

    timed   = TMO_EN && (term == T_NONE || lat > TMO);
    exp_len = timed ? TMO : lat;
    exp_err = timed || term == T_ERR || term == T_BOTH;
    exp_dat = (exp_err || we) ? '0 : rdata;

    check("accept_ready", bus.cmd_ready_o, 1'b1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'($urandom);
    bus.cmd_adr_i   = $urandom;
    bus.cmd_dat_i   = $urandom;

    for (int c = 1; c <= exp_len; c++) begin
      check("bus_cyc",   bus.wb_cyc_o,    1'b1);
      check("bus_stb",   bus.wb_stb_o,    1'b1);
      check("bus_adr",   bus.wb_adr_o,    adr);
      check("bus_we",    bus.wb_we_o,     we);
      check("bus_dat",   bus.wb_dat_o,    dat);
      check("bus_sel",   bus.wb_sel_o,    4'hF);
      check("bus_ready", bus.cmd_ready_o, 1'b0);
      check("bus_busy",  bus.busy_o,      1'b1);
      check("bus_valid", bus.rsp_valid_o, 1'b0);
      bus.wb_ack_i = (c == lat) && (term == T_ACK || term == T_BOTH);
      bus.wb_err_i = (c == lat) && (term == T_ERR || term == T_BOTH);
      bus.wb_dat_i = (c == lat) ? rdata : DW'($urandom);
      @(negedge clk);
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
    end

    check("rsp_cyc",   bus.wb_cyc_o,    1'b0);
    check("rsp_stb",   bus.wb_stb_o,    1'b0);
    check("rsp_valid", bus.rsp_valid_o, 1'b1);
    check("rsp_dat",   bus.rsp_dat_o,   exp_dat);
    check("rsp_err",   bus.rsp_err_o,   exp_err);
    check("rsp_ready", bus.cmd_ready_o, 1'b0);
    check("rsp_busy",  bus.busy_o,      1'b1);
    held_dat = exp_dat;
    held_err = exp_err;

    for (int b = 0; b < bp; b++) begin
      bus.wb_ack_i = 1'($urandom);
      bus.wb_err_i = 1'($urandom);
      bus.wb_dat_i = $urandom;
      @(negedge clk);
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
      check("bp_valid", bus.rsp_valid_o, 1'b1);
      check("bp_dat",   bus.rsp_dat_o,   held_dat);
      check("bp_err",   bus.rsp_err_o,   held_err);
      check("bp_ready", bus.cmd_ready_o, 1'b0);
      check("bp_cyc",   bus.wb_cyc_o,    1'b0);
    end

    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    check_quiet_idle("done");
  endtask

  // Accept a read that the slave never answers, hold 'hold' cycles, then reset mid-cycle
  task automatic reset_in_bus(input int hold);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = 32'h0000_0020;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    for (int c = 0; c < hold; c++) begin
      check("hold_cyc", bus.wb_cyc_o, 1'b1);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("mrst_cyc",   bus.wb_cyc_o,    1'b0);
    check("mrst_stb",   bus.wb_stb_o,    1'b0);
    check("mrst_valid", bus.rsp_valid_o, 1'b0);
    check("mrst_ready", bus.cmd_ready_o, 1'b0);
    check("mrst_busy",  bus.busy_o,      1'b0);
    check("mrst_adr",   bus.wb_adr_o,    '0);
    rst = 1'b0;
    @(negedge clk);
    check_quiet_idle("post_rst");
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    check_quiet_idle("no_rsp");
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.rsp_ready_i = 1'b0;
    bus.wb_dat_i    = '0;
    bus.wb_ack_i    = 1'b0;
    bus.wb_err_i    = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", bus.cmd_ready_o, 1'b0);
    check("rst_cyc",   bus.wb_cyc_o,    1'b0);
    check("rst_stb",   bus.wb_stb_o,    1'b0);
    check("rst_we",    bus.wb_we_o,     1'b0);
    check("rst_sel",   bus.wb_sel_o,    '0);
    check("rst_adr",   bus.wb_adr_o,    '0);
    check("rst_wdat",  bus.wb_dat_o,    '0);
    check("rst_valid", bus.rsp_valid_o, 1'b0);
    check("rst_err",   bus.rsp_err_o,   1'b0);
    check("rst_rdat",  bus.rsp_dat_o,   '0);
    check("rst_busy",  bus.busy_o,      1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_quiet_idle("release");

    txn(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 2, T_ACK, 0);
    txn(1'b1, 32'h0000_0004, 32'h1234_5678, 32'hFFFF_FFFF, 2, T_ACK, 0);
    txn(1'b0, 32'h0000_0008, 32'h0, 32'hA5A5_0F0F, 2, T_ACK, 5);
    txn(1'b0, 32'h0000_000C, 32'h0, 32'hCAFE_F00D, 5, T_BOTH, 1);
    txn(1'b1, 32'h0000_0014, 32'h0BAD_F00D, 32'h0, 3, T_ERR, 0);
    txn(1'b0, 32'h0000_0018, 32'h0, 32'h1357_9BDF, 1, T_ACK, 0);
    idle_cycles(4);

`ifdef WB_MASTER_TIMEOUT_EN
    txn(1'b0, 32'h0000_0030, 32'h0, 32'h1111_2222, 1, T_NONE, 0);
    txn(1'b0, 32'h0000_0034, 32'h0, 32'h3333_4444, TMO, T_ACK, 0);
    txn(1'b1, 32'h0000_0038, 32'h5555_6666, 32'h0, TMO + 3, T_ACK, 0);
    reset_in_bus(3);
`else
    txn(1'b0, 32'h0000_0030, 32'h0, 32'h3333_4444, 20, T_ACK, 0);
    reset_in_bus(25);
`endif

    txn(1'b0, 32'h0000_0040, 32'h0, 32'h7777_8888, 2, T_ACK, 0);

    for (int i = 0; i < 25; i++) begin
      int t;
      int sel;
      sel = int'($urandom_range(9, 0));
      t   = (sel < 6) ? T_ACK : (sel < 8) ? T_ERR : T_BOTH;
      txn(1'($urandom), $urandom, $urandom, $urandom,
          int'($urandom_range(11, 1)), t, int'($urandom_range(3, 0)));
      idle_cycles(int'($urandom_range(2, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
